// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: double-buffered, PWM-dimmed multiplexed 7-segment display driver
module seven_segment_scanner #(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 50000,
    parameter int BLANK_CYCLES     = 500,
    parameter int SEG_ACTIVE_LOW   = 0,
    parameter int DIGIT_ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7*NUM_DIGITS-1:0]   segments_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
    input  logic                      enable,
    input  logic [3:0]                brightness,
    output logic [6:0]                seg_out,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     digit_sel,
    output logic                      frame_start
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int SPAN = REFRESH_DIV - BLANK_CYCLES;
    localparam logic SEG_OFF = SEG_ACTIVE_LOW != 0;
    localparam logic DIG_OFF = DIGIT_ACTIVE_LOW != 0;

    logic [CW-1:0]           slot_cnt;
    logic [DW-1:0]           digit_idx;
    logic [7*NUM_DIGITS-1:0] shadow_seg, active_seg, seg_eff;
    logic [NUM_DIGITS-1:0]   shadow_dp, active_dp, dp_eff;
    logic [3:0]              bright_q, bright_eff;
    logic                    slot_start, frame_edge, slot_last, digit_last, lit;
    logic [31:0]             on_len, slot_ext;

    // phase decode; at a slot/frame start the freshly sampled brightness and buffer are forwarded
    always_comb begin
        slot_start = slot_cnt == '0;
        frame_edge = enable && slot_start && digit_idx == '0;
        slot_last  = slot_cnt == CW'(REFRESH_DIV - 1);
        digit_last = digit_idx == DW'(NUM_DIGITS - 1);
        bright_eff = slot_start ? brightness : bright_q;
        seg_eff    = frame_edge ? shadow_seg : active_seg;
        dp_eff     = frame_edge ? shadow_dp : active_dp;
        on_len     = (32'(SPAN) * (32'(bright_eff) + 32'd1)) >> 4;
        slot_ext   = 32'(slot_cnt);
        lit        = enable && slot_ext >= 32'(BLANK_CYCLES) && slot_ext < 32'(BLANK_CYCLES) + on_len;
    end

    // slot and digit counters; disabled display parks at digit 0, slot 0
    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else begin
            slot_cnt  <= slot_last ? '0 : slot_cnt + 1'b1;
            digit_idx <= slot_last ? (digit_last ? '0 : digit_idx + 1'b1) : digit_idx;
        end
    end

    // shadow takes loads any time; active copies shadow only at frame start to avoid tearing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_seg <= '0;
            shadow_dp  <= '0;
            active_seg <= '0;
            active_dp  <= '0;
            bright_q   <= '0;
        end else begin
            shadow_seg <= load ? segments_in : shadow_seg;
            shadow_dp  <= load ? dp_in : shadow_dp;
            active_seg <= frame_edge ? shadow_seg : active_seg;
            active_dp  <= frame_edge ? shadow_dp : active_dp;
            bright_q   <= (enable && slot_start) ? brightness : bright_q;
        end
    end

    // registered, polarity-converted drive; anything but the ON phase is fully inactive
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_out     <= {7{SEG_OFF}};
            dp_out      <= SEG_OFF;
            digit_sel   <= {NUM_DIGITS{DIG_OFF}};
            frame_start <= 1'b0;
        end else begin
            seg_out     <= lit ? seg_eff[digit_idx*7 +: 7] ^ {7{SEG_OFF}} : {7{SEG_OFF}};
            dp_out      <= lit ? dp_eff[digit_idx] ^ SEG_OFF : SEG_OFF;
            digit_sel   <= lit ? (NUM_DIGITS'(1) << digit_idx) ^ {NUM_DIGITS{DIG_OFF}} : {NUM_DIGITS{DIG_OFF}};
            frame_start <= frame_edge;
        end
    end
endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: directed checks of scanning, dimming, double buffering, enable, reset and polarity
module tb_seven_segment_scanner;
    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0][6:0] segments_in = '0;
    logic [3:0]      dp_in = '0;
    logic            load = 1'b0;
    logic            enable = 1'b0;
    logic [3:0]      brightness = '0;
    logic [6:0]      seg_out, seg_out_n;
    logic            dp_out, dp_out_n, frame_start, frame_start_n;
    logic [3:0]      digit_sel, digit_sel_n;
    int              compared = 0;
    int              mismatched = 0;

    localparam logic [13:0] INV = 14'b0_1111_1_1111111;
    localparam logic [3:0][6:0] DATA_A = {7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110};
    localparam logic [3:0][6:0] DATA_B = {7'b1111001, 7'b1001111, 7'b0110000, 7'b1111110};
    localparam logic [3:0][6:0] DATA_C = {7'b1111001, 7'b1001111, 7'b0110000, 7'b0110011};
    localparam logic [3:0] DP_A = 4'b0101;

    seven_segment_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(1),
                            .SEG_ACTIVE_LOW(0), .DIGIT_ACTIVE_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .segments_in(segments_in), .dp_in(dp_in), .load(load),
        .enable(enable), .brightness(brightness), .seg_out(seg_out), .dp_out(dp_out),
        .digit_sel(digit_sel), .frame_start(frame_start));

    seven_segment_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(1),
                            .SEG_ACTIVE_LOW(1), .DIGIT_ACTIVE_LOW(1)) dut_n (
        .clk(clk), .rst_n(rst_n), .segments_in(segments_in), .dp_in(dp_in), .load(load),
        .enable(enable), .brightness(brightness), .seg_out(seg_out_n), .dp_out(dp_out_n),
        .digit_sel(digit_sel_n), .frame_start(frame_start_n));

    always #5 clk = ~clk;

    // expected active-high {frame_start, digit_sel, dp_out, seg_out} for cycle c after an enable/reset restart
    function automatic logic [13:0] exp_out(input int c, input int on_len, input logic [3:0][6:0] d, input logic [3:0] dp);
        int   slot;
        int   dig;
        logic lit;
        slot = c % 8;
        dig  = (c / 8) % 4;
        lit  = slot >= 1 && slot < 1 + on_len;
        return {c % 32 == 0, lit ? 4'(1 << dig) : 4'b0, lit ? dp[dig] : 1'b0, lit ? d[dig] : 7'b0};
    endfunction

    task automatic restart(input logic [3:0] b);
        enable = 1'b0;
        brightness = b;
        @(negedge clk);
        compared++;
        if ({frame_start, digit_sel, dp_out, seg_out} !== 14'b0) begin
            mismatched++;
            $display("FAIL restart_dark got %b expected %b", {frame_start, digit_sel, dp_out, seg_out}, 14'b0);
        end
        enable = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        enable = 1'b1;
        segments_in = DATA_A;
        load = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if ({frame_start, digit_sel, dp_out, seg_out} !== 14'b0) begin
            mismatched++;
            $display("FAIL reset_high got %b expected %b", {frame_start, digit_sel, dp_out, seg_out}, 14'b0);
        end
        compared++;
        if ({frame_start_n, digit_sel_n, dp_out_n, seg_out_n} !== INV) begin
            mismatched++;
            $display("FAIL reset_low got %b expected %b", {frame_start_n, digit_sel_n, dp_out_n, seg_out_n}, INV);
        end
        rst_n = 1'b1;
        enable = 1'b0;
        load = 1'b0;
        @(negedge clk);
        compared++;
        if ({frame_start, digit_sel, dp_out, seg_out} !== 14'b0) begin
            mismatched++;
            $display("FAIL disabled_dark got %b expected %b", {frame_start, digit_sel, dp_out, seg_out}, 14'b0);
        end
    endtask

    task automatic test_scan;
        logic [13:0] e;
        segments_in = DATA_A;
        dp_in = DP_A;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        restart(4'd15);
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            e = exp_out(c, 7, DATA_A, DP_A);
            compared++;
            if ({frame_start, digit_sel, dp_out, seg_out} !== e) begin
                mismatched++;
                $display("FAIL scan c=%0d got %b expected %b", c, {frame_start, digit_sel, dp_out, seg_out}, e);
            end
            compared++;
            if ({frame_start_n, digit_sel_n, dp_out_n, seg_out_n} !== (e ^ INV)) begin
                mismatched++;
                $display("FAIL scan_low c=%0d got %b expected %b", c, {frame_start_n, digit_sel_n, dp_out_n, seg_out_n}, e ^ INV);
            end
        end
    endtask

    task automatic test_brightness;
        logic [13:0] e;
        restart(4'd7);
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            e = exp_out(c, 3, DATA_A, DP_A);
            compared++;
            if ({frame_start, digit_sel, dp_out, seg_out} !== e) begin
                mismatched++;
                $display("FAIL bright7 c=%0d got %b expected %b", c, {frame_start, digit_sel, dp_out, seg_out}, e);
            end
        end
        restart(4'd0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            e = exp_out(c, 0, DATA_A, DP_A);
            compared++;
            if ({frame_start, digit_sel, dp_out, seg_out} !== e) begin
                mismatched++;
                $display("FAIL bright0 c=%0d got %b expected %b", c, {frame_start, digit_sel, dp_out, seg_out}, e);
            end
        end
    endtask

    task automatic test_active_low;
        restart(4'd15);
        @(negedge clk);
        compared++;
        if ({frame_start_n, digit_sel_n, dp_out_n, seg_out_n} !== 14'b1_1111_1_1111111) begin
            mismatched++;
            $display("FAIL active_low_blank got %b expected %b", {frame_start_n, digit_sel_n, dp_out_n, seg_out_n}, 14'b1_1111_1_1111111);
        end
        @(negedge clk);
        compared++;
        if ({frame_start_n, digit_sel_n, dp_out_n, seg_out_n} !== 14'b0_1110_0_0000001) begin
            mismatched++;
            $display("FAIL active_low_digit0 got %b expected %b", {frame_start_n, digit_sel_n, dp_out_n, seg_out_n}, 14'b0_1110_0_0000001);
        end
    endtask

    task automatic test_double_buffer;
        logic [13:0] e;
        restart(4'd15);
        for (int c = 0; c < 96; c++) begin
            @(negedge clk);
            e = exp_out(c, 7, c < 32 ? DATA_A : c < 64 ? DATA_B : DATA_C, DP_A);
            compared++;
            if ({frame_start, digit_sel, dp_out, seg_out} !== e) begin
                mismatched++;
                $display("FAIL double_buffer c=%0d got %b expected %b", c, {frame_start, digit_sel, dp_out, seg_out}, e);
            end
            load = c == 10 || c == 31;
            segments_in = c == 10 ? DATA_B : c == 31 ? DATA_C : segments_in;
        end
        load = 1'b0;
    endtask

    task automatic test_enable_drop;
        logic [13:0] e;
        restart(4'd15);
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            e = exp_out(c, 7, DATA_C, DP_A);
            compared++;
            if ({frame_start, digit_sel, dp_out, seg_out} !== e) begin
                mismatched++;
                $display("FAIL pre_drop c=%0d got %b expected %b", c, {frame_start, digit_sel, dp_out, seg_out}, e);
            end
        end
        enable = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            compared++;
            if ({frame_start, digit_sel, dp_out, seg_out} !== 14'b0) begin
                mismatched++;
                $display("FAIL dropped c=%0d got %b expected %b", c, {frame_start, digit_sel, dp_out, seg_out}, 14'b0);
            end
        end
        enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            e = exp_out(c, 7, DATA_C, DP_A);
            compared++;
            if ({frame_start, digit_sel, dp_out, seg_out} !== e) begin
                mismatched++;
                $display("FAIL reenable c=%0d got %b expected %b", c, {frame_start, digit_sel, dp_out, seg_out}, e);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [13:0] e;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        compared++;
        if ({frame_start, digit_sel, dp_out, seg_out} !== 14'b0) begin
            mismatched++;
            $display("FAIL mid_reset got %b expected %b", {frame_start, digit_sel, dp_out, seg_out}, 14'b0);
        end
        compared++;
        if ({frame_start_n, digit_sel_n, dp_out_n, seg_out_n} !== INV) begin
            mismatched++;
            $display("FAIL mid_reset_low got %b expected %b", {frame_start_n, digit_sel_n, dp_out_n, seg_out_n}, INV);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            e = exp_out(c, 7, '0, 4'b0);
            compared++;
            if ({frame_start, digit_sel, dp_out, seg_out} !== e) begin
                mismatched++;
                $display("FAIL post_reset_blank c=%0d got %b expected %b", c, {frame_start, digit_sel, dp_out, seg_out}, e);
            end
            compared++;
            if ({frame_start_n, digit_sel_n, dp_out_n, seg_out_n} !== (e ^ INV)) begin
                mismatched++;
                $display("FAIL post_reset_low c=%0d got %b expected %b", c, {frame_start_n, digit_sel_n, dp_out_n, seg_out_n}, e ^ INV);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_scan;
        test_brightness;
        test_active_low;
        test_double_buffer;
        test_enable_drop;
        test_reset_mid_frame;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
